// File: rtl/pc_unit_pkg.sv
// pc_unit shared definitions: widths, vectors, FSM encoding.
// Imported by the next-PC calculator and the PC sequencer top.
package pc_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VEC = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100;
  localparam logic [XLEN-1:0] SEQ_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_TRAP = 2'b11
  } pc_state_e;

  // A redirect target is unusable when it is not word aligned in bit 1.
  function automatic logic tgt_misaligned(
    input logic [XLEN-1:0] tgt
  );
    return tgt[1];
  endfunction

endpackage

// File: rtl/pc_unit_next_pc_calc.sv
// next_pc_calc: selects sequential, branch or jump target.
// Purely combinational; flags misaligned redirect targets.
module next_pc_calc
  import pc_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_branch,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_zero,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_jsum;
  logic [XLEN-1:0] w_jtgt;
  logic            w_take;
  logic            w_redir;

  assign w_seq  = i_pc + SEQ_STEP;
  assign w_rel  = i_pc + i_imm;
  assign w_jsum = i_rs1 + i_imm;
  assign w_jtgt = {w_jsum[XLEN-1:1], 1'b0};
  assign w_take = i_branch & i_zero;

  // Several control bits may be high at once; jalr wins, then jal.
  always_comb begin
    o_next_pc = w_seq;
    w_redir   = 1'b0;
    priority case (1'b1)
      i_jalr: begin
        o_next_pc = w_jtgt;
        w_redir   = 1'b1;
      end
      i_jal: begin
        o_next_pc = w_rel;
        w_redir   = 1'b1;
      end
      w_take: begin
        o_next_pc = w_rel;
        w_redir   = 1'b1;
      end
      default: begin
        o_next_pc = w_seq;
        w_redir   = 1'b0;
      end
    endcase
  end

  assign o_misalign = w_redir & tgt_misaligned(o_next_pc);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, fetch handshake, trap/halt FSM and
// retired-instruction counter for the single-cycle core.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VEC,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VEC
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        if_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_req,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] instret,
  output logic [1:0]  state
);

  pc_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_trap_pc;
  logic [31:0] r_instret;
  logic        r_if_req;
  logic        r_trap;

  logic [31:0] w_next_pc;
  logic        w_misalign;
  logic        w_fire;

  next_pc_calc u_npc (
    .i_pc       (r_pc),
    .i_imm      (imm),
    .i_rs1      (rs1),
    .i_branch   (branch),
    .i_jal      (jal),
    .i_jalr     (jalr),
    .i_zero     (zero),
    .o_next_pc  (w_next_pc),
    .o_misalign (w_misalign)
  );

  assign w_fire = (r_state == ST_RUN) & r_if_req
                & if_ack & ~stall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_RST;
      r_pc      <= RESET_VECTOR;
      r_trap_pc <= '0;
      r_instret <= '0;
      r_if_req  <= 1'b0;
      r_trap    <= 1'b0;
    end else begin
      r_trap <= 1'b0;
      unique case (r_state)
        ST_RST: begin
          r_state  <= ST_RUN;
          r_if_req <= 1'b1;
        end
        ST_RUN: begin
          if (w_fire) begin
            r_instret <= r_instret + 32'd1;
            // A faulting redirect beats a pending halt request.
            if (w_misalign) begin
              r_pc      <= TRAP_VECTOR;
              r_trap_pc <= w_next_pc;
              r_trap    <= 1'b1;
              r_state   <= ST_TRAP;
              r_if_req  <= 1'b0;
            end else begin
              r_pc <= w_next_pc;
              if (halt_req) begin
                r_state  <= ST_HALT;
                r_if_req <= 1'b0;
              end
            end
          end
        end
        ST_HALT: begin
          if (resume) begin
            r_state  <= ST_RUN;
            r_if_req <= 1'b1;
          end
        end
        ST_TRAP: begin
          r_state  <= ST_RUN;
          r_if_req <= 1'b1;
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = r_pc + 32'd4;
  assign if_req   = r_if_req;
  assign trap     = r_trap;
  assign trap_pc  = r_trap_pc;
  assign instret  = r_instret;
  assign state    = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for the PC sequencer.
// Expected per-cycle outputs are queued with the stimulus.
module tb_pc_unit;

  localparam logic [1:0] S_RST  = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  localparam logic [1:0] S_TRAP = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        branch, jal, jalr, zero;
  logic [31:0] imm, rs1;
  logic        stall, halt_req, resume, if_ack;
  logic [31:0] pc, pc_plus4, trap_pc, instret;
  logic        if_req, trap;
  logic [1:0]  state;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        req;
    logic        trp;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   n_run;
  int   n_fail;
  int   step;

  pc_unit dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .branch    (branch),
    .jal       (jal),
    .jalr      (jalr),
    .zero      (zero),
    .imm       (imm),
    .rs1       (rs1),
    .stall     (stall),
    .halt_req  (halt_req),
    .resume    (resume),
    .if_ack    (if_ack),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .if_req    (if_req),
    .trap      (trap),
    .trap_pc   (trap_pc),
    .instret   (instret),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ctl_clr();
    branch = 0; jal = 0; jalr = 0; zero = 0;
    imm = '0; rs1 = '0; stall = 0;
    halt_req = 0; resume = 0;
  endtask

  task automatic tick(input logic [31:0] epc, input logic [31:0] ein,
                      input logic ereq, input logic etrp,
                      input logic [1:0] est);
    exp_t e;
    e = '{pc: epc, ins: ein, req: ereq, trp: etrp, st: est};
    sb.push_back(e);
    @(posedge clk);
    #1;
    step++;
    e = sb.pop_front();
    chk($sformatf("pc@%0d", step), pc, e.pc);
    chk($sformatf("instret@%0d", step), instret, e.ins);
    chk($sformatf("if_req@%0d", step), 32'(if_req), 32'(e.req));
    chk($sformatf("trap@%0d", step), 32'(trap), 32'(e.trp));
    chk($sformatf("state@%0d", step), 32'(state), 32'(e.st));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_state"}, 32'(state), 32'(S_RST));
    chk({tag, "_if_req"}, 32'(if_req), 32'h0);
    chk({tag, "_trap"}, 32'(trap), 32'h0);
    chk({tag, "_trap_pc"}, trap_pc, 32'h0);
    chk({tag, "_instret"}, instret, 32'h0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1 chk_reset(tag);
    @(posedge clk);
    #1 chk_reset({tag, "_hold"});
    rst_n = 1;
  endtask

  initial begin
    n_run = 0; n_fail = 0; step = 0;
    rst_n = 0; if_ack = 0;
    ctl_clr();
    #2 chk_reset("por");
    #10 rst_n = 1;
    if_ack = 1;
    // sequential fetch from reset
    tick(32'h0, 0, 1, 0, S_RUN);
    tick(32'h4, 1, 1, 0, S_RUN);
    tick(32'h8, 2, 1, 0, S_RUN);
    tick(32'hC, 3, 1, 0, S_RUN);
    tick(32'h10, 4, 1, 0, S_RUN);
    // taken branch backwards, wraps through zero arithmetic
    branch = 1; zero = 1; imm = 32'hFFFF_FFF0;
    tick(32'h0, 5, 1, 0, S_RUN);
    ctl_clr(); jal = 1; imm = 32'h10;
    tick(32'h10, 6, 1, 0, S_RUN);
    ctl_clr(); branch = 1; zero = 0; imm = 32'hFFFF_FFF0;
    tick(32'h14, 7, 1, 0, S_RUN);
    chk("pc_plus4", pc_plus4, 32'h18);
    // jalr clears bit 0
    ctl_clr(); jalr = 1; rs1 = 32'h101; imm = 32'h4;
    tick(32'h104, 8, 1, 0, S_RUN);
    // jalr to 0x102 traps
    ctl_clr(); jalr = 1; rs1 = 32'h102; imm = 32'h0;
    tick(32'h100, 9, 0, 1, S_TRAP);
    chk("trap_pc_jalr", trap_pc, 32'h102);
    ctl_clr();
    tick(32'h100, 9, 1, 0, S_RUN);
    // jalr outranks jal
    jalr = 1; jal = 1; rs1 = 32'h200; imm = 32'h8;
    tick(32'h208, 10, 1, 0, S_RUN);
    // misaligned taken branch
    ctl_clr(); branch = 1; zero = 1; imm = 32'h2;
    tick(32'h100, 11, 0, 1, S_TRAP);
    chk("trap_pc_br", trap_pc, 32'h20A);
    ctl_clr();
    tick(32'h100, 11, 1, 0, S_RUN);
    // ack withheld, then a stall cycle
    if_ack = 0;
    for (int i = 0; i < 3; i++) tick(32'h100, 11, 1, 0, S_RUN);
    if_ack = 1; stall = 1;
    tick(32'h100, 11, 1, 0, S_RUN);
    stall = 0;
    tick(32'h104, 12, 1, 0, S_RUN);
    // halt after jal at 0x40
    jalr = 1; rs1 = 32'h40;
    tick(32'h40, 13, 1, 0, S_RUN);
    ctl_clr(); jal = 1; imm = 32'h20; halt_req = 1;
    tick(32'h60, 14, 0, 0, S_HALT);
    ctl_clr();
    tick(32'h60, 14, 0, 0, S_HALT);
    halt_req = 1;
    tick(32'h60, 14, 0, 0, S_HALT);
    ctl_clr(); resume = 1;
    tick(32'h60, 14, 1, 0, S_RUN);
    ctl_clr();
    tick(32'h64, 15, 1, 0, S_RUN);
    // trap wins over halt_req
    jal = 1; imm = 32'h2; halt_req = 1;
    tick(32'h100, 16, 0, 1, S_TRAP);
    chk("trap_pc_halt", trap_pc, 32'h66);
    ctl_clr();
    tick(32'h100, 16, 1, 0, S_RUN);
    tick(32'h104, 17, 1, 0, S_RUN);
    // async reset in HALT with a saturated counter
    halt_req = 1;
    tick(32'h108, 18, 0, 0, S_HALT);
    ctl_clr();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    tick(32'h108, 32'hFFFF_FFFF, 0, 0, S_HALT);
    async_reset("rst_halt");
    tick(32'h0, 0, 1, 0, S_RUN);
    // counter wrap
    halt_req = 1;
    tick(32'h4, 1, 0, 0, S_HALT);
    ctl_clr();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    resume = 1;
    tick(32'h4, 32'hFFFF_FFFF, 1, 0, S_RUN);
    ctl_clr();
    tick(32'h8, 32'h0, 1, 0, S_RUN);
    // async reset mid-TRAP
    jalr = 1; rs1 = 32'h2;
    tick(32'h100, 1, 0, 1, S_TRAP);
    ctl_clr();
    async_reset("rst_trap");
    tick(32'h0, 0, 1, 0, S_RUN);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
